kamacore_mem_arbiter: RTL and testbench

//  Shares the single read/write port (a/di/we/spo) of kamacore_memory between two requesters:
//  the core load/store unit (C) and the program loader/debug master (L).
//  The dpra/dpo instruction-fetch read port stays wired to fetch and is not arbitrated here.

---
 rtl/kamacore_mem_arbiter_if.sv | 24 ++
 rtl/kamacore_mem_arbiter.sv | 104 ++++++++++
 tb/tb_kamacore_mem_arbiter.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/kamacore_mem_arbiter_if.sv
// Request/response bundle for one requester of the shared kamacore_memory port.
// The requester drives the request fields; the arbiter returns ready and the response.
interface kamacore_mem_arbiter_if #(
  parameter int AW = 10,
  parameter int DW = 32
);
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/kamacore_mem_arbiter.sv
// Arbitrates the single a/di/we/spo memory port between the core (c) and the loader (l):
// fixed priority to c, a starvation counter for l, and a lock mode giving l exclusive use.
module kamacore_mem_arbiter #(
  parameter int MEM_ADDR_WIDTH = 10,
  parameter int CPU_WIDTH      = 32,
  parameter int STARVE_LIMIT   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  kamacore_mem_arbiter_if.slave     c,
  kamacore_mem_arbiter_if.slave     l,
  input  logic                      l_lock,
  output logic                      mem_we,
  output logic [MEM_ADDR_WIDTH-1:0] mem_a,
  output logic [CPU_WIDTH-1:0]      mem_di,
  input  logic [CPU_WIDTH-1:0]      mem_spo
);

  localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

  typedef enum logic {SHARED = 1'b0, LOCKED = 1'b1} state_t;

  state_t         state_reg, state_next;
  logic [7:0]     starve_cnt_reg, starve_cnt_next;
  logic           c_grant, l_grant, l_starved;

  logic                 c_rsp_valid_reg, l_rsp_valid_reg;
  logic [CPU_WIDTH-1:0] c_rsp_rdata_reg, l_rsp_rdata_reg;

  assign l_starved = (starve_cnt_reg == STARVE_MAX) && l.req_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= SHARED;
      starve_cnt_reg <= 8'd0;
    end else begin
      state_reg      <= state_next;
      starve_cnt_reg <= starve_cnt_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    starve_cnt_next = starve_cnt_reg;
    case (state_reg)
      SHARED:  if (l_grant && l_lock) state_next = LOCKED;
      LOCKED:  if (!l_lock)           state_next = SHARED;
      default:                        state_next = SHARED;
    endcase
    // Only waiting while blocked accumulates; any l transfer or idle l clears it.
    if (!l.req_valid || l_grant)
      starve_cnt_next = 8'd0;
    else if (starve_cnt_reg != STARVE_MAX)
      starve_cnt_next = starve_cnt_reg + 8'd1;
  end

  always_comb begin
    c_grant = 1'b0;
    l_grant = 1'b0;
    if (state_reg == LOCKED)
      l_grant = l.req_valid;
    else if (c.req_valid && !l_starved)
      c_grant = 1'b1;
    else
      l_grant = l.req_valid;

    c.req_ready = c_grant;
    l.req_ready = l_grant;

    mem_we = 1'b0;
    mem_a  = '0;
    mem_di = '0;
    if (c_grant) begin
      mem_we = c.req_we;
      mem_a  = c.req_addr;
      mem_di = c.req_wdata;
    end else if (l_grant) begin
      mem_we = l.req_we;
      mem_a  = l.req_addr;
      mem_di = l.req_wdata;
    end
  end

  // spo is an asynchronous read of mem_a, so writes return the pre-write contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_rsp_valid_reg <= 1'b0;
      l_rsp_valid_reg <= 1'b0;
      c_rsp_rdata_reg <= '0;
      l_rsp_rdata_reg <= '0;
    end else begin
      c_rsp_valid_reg <= c_grant;
      l_rsp_valid_reg <= l_grant;
      if (c_grant) c_rsp_rdata_reg <= mem_spo;
      if (l_grant) l_rsp_rdata_reg <= mem_spo;
    end
  end

  assign c.rsp_valid = c_rsp_valid_reg;
  assign c.rsp_rdata = c_rsp_rdata_reg;
  assign l.rsp_valid = l_rsp_valid_reg;
  assign l.rsp_rdata = l_rsp_rdata_reg;

endmodule

// File: tb/tb_kamacore_mem_arbiter.sv
// Directed bench for kamacore_mem_arbiter: stimulus pushes expected response data into
// per-requester queues and a negedge monitor pops and compares every response.
module tb_kamacore_mem_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          l_lock = 1'b0;
  logic          mem_we;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_di;
  logic [DW-1:0] mem_spo;
  logic [DW-1:0] mem [0:(1<<AW)-1];

  kamacore_mem_arbiter_if #(.AW(AW), .DW(DW)) c_if ();
  kamacore_mem_arbiter_if #(.AW(AW), .DW(DW)) l_if ();

  kamacore_mem_arbiter #(
    .MEM_ADDR_WIDTH(AW),
    .CPU_WIDTH     (DW),
    .STARVE_LIMIT  (4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .c      (c_if),
    .l      (l_if),
    .l_lock (l_lock),
    .mem_we (mem_we),
    .mem_a  (mem_a),
    .mem_di (mem_di),
    .mem_spo(mem_spo)
  );

  always #5 clk = ~clk;

  // Memory model: background mem[i] = 0xA0000000 + i, asynchronous read.
  assign mem_spo = mem[mem_a];
  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'hA000_0000 + 32'(i);
    mem[5] = 32'h0070_0093;
    mem[8] = 32'h0000_0011;
    forever begin
      @(posedge clk);
      if (mem_we) mem[mem_a] <= mem_di;
    end
  end

  int n_checks = 0;
  int n_fails  = 0;
  logic [DW-1:0] c_exp_q[$];
  logic [DW-1:0] l_exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Response monitor
  always @(negedge clk) begin : monitor
    logic [DW-1:0] e;
    if (!rst) begin
      if (c_if.rsp_valid) begin
        if (c_exp_q.size() == 0) begin
          n_checks++; n_fails++;
          $display("FAIL c_rsp_unexpected: got rdata 0x%08h, expected no response", c_if.rsp_rdata);
        end else begin
          e = c_exp_q.pop_front();
          check("c_rsp_rdata", c_if.rsp_rdata, e);
          $display("t=%0t c rsp rdata=0x%08h exp=0x%08h", $time, c_if.rsp_rdata, e);
        end
      end
      if (l_if.rsp_valid) begin
        if (l_exp_q.size() == 0) begin
          n_checks++; n_fails++;
          $display("FAIL l_rsp_unexpected: got rdata 0x%08h, expected no response", l_if.rsp_rdata);
        end else begin
          e = l_exp_q.pop_front();
          check("l_rsp_rdata", l_if.rsp_rdata, e);
          $display("t=%0t l rsp rdata=0x%08h exp=0x%08h", $time, l_if.rsp_rdata, e);
        end
      end
    end
  end

  task automatic drive_c(input logic v, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    c_if.req_valid = v; c_if.req_we = we; c_if.req_addr = a; c_if.req_wdata = d;
  endtask

  task automatic drive_l(input logic v, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    l_if.req_valid = v; l_if.req_we = we; l_if.req_addr = a; l_if.req_wdata = d;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic exp_c;
    drive_c(1'b0, 1'b0, '0, '0);
    drive_l(1'b0, 1'b0, '0, '0);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_c_rsp_valid", 32'(c_if.rsp_valid), 32'd0);
    check("rst_c_rsp_rdata", c_if.rsp_rdata, 32'd0);
    check("rst_l_rsp_valid", 32'(l_if.rsp_valid), 32'd0);
    check("rst_mem_ctl", 32'({mem_we, mem_a}), 32'd0);
    step;
    rst = 1'b0;

    // 1: core read, same-cycle ready, 1-cycle latency
    drive_c(1'b1, 1'b0, 10'd5, '0);
    @(negedge clk);
    check("t1_c_ready", 32'(c_if.req_ready), 32'd1);
    check("t1_l_ready", 32'(l_if.req_ready), 32'd0);
    check("t1_mem_a", 32'(mem_a), 32'd5);
    check("t1_mem_we", 32'(mem_we), 32'd0);
    c_exp_q.push_back(32'h0070_0093);
    step;
    drive_c(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    check("t1_rsp_latency", 32'(c_if.rsp_valid), 32'd1);
    step;

    // 2: write returns old data, readback returns new data
    drive_c(1'b1, 1'b1, 10'd8, 32'hDEAD_BEEF);
    @(negedge clk);
    check("t2_c_ready", 32'(c_if.req_ready), 32'd1);
    check("t2_mem_we", 32'(mem_we), 32'd1);
    check("t2_mem_di", mem_di, 32'hDEAD_BEEF);
    c_exp_q.push_back(32'h0000_0011);
    step;
    drive_c(1'b1, 1'b0, 10'd8, '0);
    @(negedge clk);
    check("t2_rd_ready", 32'(c_if.req_ready), 32'd1);
    c_exp_q.push_back(32'hDEAD_BEEF);
    step;
    drive_c(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    step;

    // 3: starvation, STARVE_LIMIT=4 -> C C C C L repeating
    for (int k = 0; k < 10; k++) begin
      drive_c(1'b1, 1'b0, 10'(16 + k), '0);
      drive_l(1'b1, 1'b0, 10'(32 + k), '0);
      exp_c = ((k % 5) != 4);
      @(negedge clk);
      check("t3_c_ready", 32'(c_if.req_ready), 32'(exp_c));
      check("t3_l_ready", 32'(l_if.req_ready), 32'(!exp_c));
      if (exp_c) c_exp_q.push_back(32'hA000_0000 + 32'(16 + k));
      else       l_exp_q.push_back(32'hA000_0000 + 32'(32 + k));
      step;
    end
    drive_c(1'b0, 1'b0, '0, '0);
    drive_l(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    step;

    // 4: lock mode
    drive_l(1'b1, 1'b1, 10'd0, 32'h100);
    l_lock = 1'b1;
    @(negedge clk);
    check("t4_l_lock_ready", 32'(l_if.req_ready), 32'd1);
    l_exp_q.push_back(32'hA000_0000);
    step;
    for (int k = 1; k <= 3; k++) begin
      drive_l(1'b1, 1'b1, 10'(k), 32'h100 + 32'(k));
      drive_c(1'b1, 1'b0, 10'd4, '0);
      @(negedge clk);
      check("t4_c_blocked", 32'(c_if.req_ready), 32'd0);
      check("t4_l_ready", 32'(l_if.req_ready), 32'd1);
      l_exp_q.push_back(32'hA000_0000 + 32'(k));
      step;
    end
    drive_l(1'b0, 1'b0, '0, '0);
    l_lock = 1'b0;
    @(negedge clk);
    check("t4_c_still_locked", 32'(c_if.req_ready), 32'd0);
    step;
    @(negedge clk);
    check("t4_c_after_unlock", 32'(c_if.req_ready), 32'd1);
    c_exp_q.push_back(32'hA000_0004);
    step;
    drive_c(1'b1, 1'b0, 10'd2, '0);
    @(negedge clk);
    check("t4_readback_ready", 32'(c_if.req_ready), 32'd1);
    c_exp_q.push_back(32'h0000_0102);
    step;

    // l_lock without an l transfer leaves the port shared
    l_lock = 1'b1;
    drive_c(1'b1, 1'b0, 10'd3, '0);
    @(negedge clk);
    check("t4_lock_idle_c_ready", 32'(c_if.req_ready), 32'd1);
    c_exp_q.push_back(32'h0000_0103);
    step;
    drive_c(1'b1, 1'b0, 10'd1, '0);
    @(negedge clk);
    check("t4_lock_idle_c_ready2", 32'(c_if.req_ready), 32'd1);
    c_exp_q.push_back(32'h0000_0101);
    step;
    l_lock = 1'b0;
    drive_c(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    step;

    // 5: reset mid-transaction drops the pending response
    drive_c(1'b1, 1'b0, 10'd6, '0);
    @(negedge clk);
    check("t5_c_ready", 32'(c_if.req_ready), 32'd1);
    step;
    rst = 1'b1;
    drive_c(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    check("t5_c_rsp_dropped", 32'(c_if.rsp_valid), 32'd0);
    check("t5_c_rdata_cleared", c_if.rsp_rdata, 32'd0);
    check("t5_mem_ctl", 32'({mem_we, mem_a}), 32'd0);
    check("t5_mem_di", mem_di, 32'd0);
    step;
    rst = 1'b0;
    drive_l(1'b1, 1'b1, 10'd10, 32'h55);
    l_lock = 1'b1;
    @(negedge clk);
    check("t5_l_lock_ready", 32'(l_if.req_ready), 32'd1);
    step;
    rst = 1'b1;
    drive_l(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    check("t5_l_rsp_dropped", 32'(l_if.rsp_valid), 32'd0);
    step;
    rst = 1'b0;
    drive_c(1'b1, 1'b0, 10'd7, '0);
    @(negedge clk);
    check("t5_shared_after_rst", 32'(c_if.req_ready), 32'd1);
    c_exp_q.push_back(32'hA000_0007);
    step;
    drive_c(1'b0, 1'b0, '0, '0);
    l_lock = 1'b0;
    @(negedge clk);
    step;

    // 6: idle
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("t6_idle_ctl", 32'({mem_we, c_if.rsp_valid, l_if.rsp_valid, mem_a}), 32'd0);
      check("t6_idle_di", mem_di, 32'd0);
      step;
    end

    check("c_queue_drained", 32'(c_exp_q.size()), 32'd0);
    check("l_queue_drained", 32'(l_exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
